axi_lite_regbank: RTL and testbench

- Parametrised AXI4-Lite slave register bank, replacing the fixed three-register AXI interface.
- Presents NUM_REGS software-visible registers at consecutive word offsets. Each is read/write (held here) or read-only (sourced from fabric).
- Implements full AXI4-Lite handshakes: independent AW/W acceptance, held B/R responses, byte strobes, SLVERR on bad accesses.
- Emits per-register write and read strobes for downstream logic (SPI engine, FIFOs, clear-on-read status).

---
 rtl/axi_lite_regbank_if.sv | 71 +++++++
 rtl/axi_lite_regbank.sv | 205 ++++++++++++++++++++
 tb/tb_axi_lite_regbank.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_regbank_if.sv
// axi_lite_regbank_if
//   AXI4-Lite bus bundle shared by the register bank (slave) and whatever
//   drives it (master). The five channels are grouped here so that the top
//   level only carries clock, reset and the fabric-side vectors.
//
//   Parameters:
//     ADDR_W  significant address bits
//     DATA_W  data width (32 or 64)
//
//   Signals:
//     AW: awaddr, awprot, awvalid, awready
//     W : wdata, wstrb, wvalid, wready
//     B : bresp, bvalid, bready
//     AR: araddr, arprot, arvalid, arready
//     R : rdata, rresp, rvalid, rready
interface axi_lite_regbank_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0]     awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;

  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  wvalid;
  logic                  wready;

  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  logic [ADDR_W-1:0]     araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;

  logic [DATA_W-1:0]     rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport slave (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );

  modport master (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

endinterface

// File: rtl/axi_lite_regbank.sv
// axi_lite_regbank
//   Parametrised AXI4-Lite slave register bank. NUM_REGS word-sized registers
//   sit at consecutive word offsets; each is either read/write (stored here)
//   or read-only (sourced from fabric through i_ro_regs). Per-register
//   one-cycle write/read strobes let downstream logic react to accesses.
//
//   Ports:
//     FCLK_CLK0    clock, all logic on the rising edge
//     RST          synchronous active-high reset
//     AXI          AXI4-Lite slave modport (AW/W/B/AR/R channels)
//     o_regs       RW register contents, reg i at [i*DATA_W +: DATA_W],
//                  RO slots drive zero
//     i_ro_regs    RO register sources, same packing, RW slots ignored
//     o_wr_strobe  one-cycle pulse per successful write, one bit per register
//     o_rd_strobe  one-cycle pulse per successful read, one bit per register
module axi_lite_regbank #(
  parameter int                  DATA_W   = 32,
  parameter int                  ADDR_W   = 16,
  parameter int                  NUM_REGS = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
  input  logic                         FCLK_CLK0,
  input  logic                         RST,
  axi_lite_regbank_if.slave            AXI,
  output logic [NUM_REGS*DATA_W-1:0]   o_regs,
  input  logic [NUM_REGS*DATA_W-1:0]   i_ro_regs,
  output logic [NUM_REGS-1:0]          o_wr_strobe,
  output logic [NUM_REGS-1:0]          o_rd_strobe
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_W - LSB;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Write-side holding state: address and data may arrive in either order,
  // so each is parked here until its partner shows up.
  logic              aw_held;
  logic              w_held;
  logic [IDX_W-1:0]  aw_idx_q;
  logic [DATA_W-1:0] w_data_q;
  logic [STRB_W-1:0] w_strb_q;
  logic              bvalid_q;
  logic [1:0]        bresp_q;

  logic              rvalid_q;
  logic [1:0]        rresp_q;
  logic [DATA_W-1:0] rdata_q;

  logic              aw_ready;
  logic              w_ready;
  logic              ar_ready;
  logic              aw_hs;
  logic              w_hs;
  logic              ar_hs;
  logic              commit;

  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic [STRB_W-1:0] wr_strb;
  logic [NUM_REGS-1:0] wr_sel;
  logic              wr_ok;

  logic [IDX_W-1:0]  rd_idx;
  logic [NUM_REGS-1:0] rd_sel;
  logic [DATA_W-1:0] rd_word;

  assign aw_ready = ~aw_held & ~bvalid_q;
  assign w_ready  = ~w_held & ~bvalid_q;
  assign ar_ready = ~rvalid_q;

  assign aw_hs = AXI.awvalid & aw_ready;
  assign w_hs  = AXI.wvalid & w_ready;
  assign ar_hs = AXI.arvalid & ar_ready;

  // A commit needs both halves, each either already held or handshaking now.
  assign commit = (aw_held | aw_hs) & (w_held | w_hs);

  assign wr_idx  = aw_held ? aw_idx_q : AXI.awaddr[ADDR_W-1:LSB];
  assign wr_data = w_held ? w_data_q : AXI.wdata;
  assign wr_strb = w_held ? w_strb_q : AXI.wstrb;
  assign rd_idx  = AXI.araddr[ADDR_W-1:LSB];

  assign AXI.awready = aw_ready;
  assign AXI.wready  = w_ready;
  assign AXI.bvalid  = bvalid_q;
  assign AXI.bresp   = bresp_q;
  assign AXI.arready = ar_ready;
  assign AXI.rvalid  = rvalid_q;
  assign AXI.rresp   = rresp_q;
  assign AXI.rdata   = rdata_q;

  // One-hot write target; stays zero for RO or out-of-range indices, so it
  // doubles as the error test and as the strobe pattern.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (32'(wr_idx) == i && !RO_MASK[i]) wr_sel[i] = 1'b1;
    end
  end

  assign wr_ok = |wr_sel;

  // One-hot read target plus the word it selects (RO slots read fabric).
  always_comb begin
    rd_sel  = '0;
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (32'(rd_idx) == i) begin
        rd_sel[i] = 1'b1;
        rd_word   = RO_MASK[i] ? i_ro_regs[i*DATA_W +: DATA_W] : regs[i];
      end
    end
  end

  // Register storage with byte-lane write enables.
  always_ff @(posedge FCLK_CLK0) begin
    if (RST) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (commit) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_sel[i]) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (wr_strb[b]) regs[i][b*8 +: 8] <= wr_data[b*8 +: 8];
          end
        end
      end
    end
  end

  // Write channel: park AW/W, commit when both present, then hold B until
  // the master takes it. Nothing new is accepted while B is pending.
  always_ff @(posedge FCLK_CLK0) begin
    if (RST) begin
      aw_held     <= 1'b0;
      w_held      <= 1'b0;
      aw_idx_q    <= '0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      bvalid_q    <= 1'b0;
      bresp_q     <= RESP_OKAY;
      o_wr_strobe <= '0;
    end else begin
      o_wr_strobe <= '0;
      if (bvalid_q && AXI.bready) bvalid_q <= 1'b0;
      if (commit) begin
        aw_held     <= 1'b0;
        w_held      <= 1'b0;
        bvalid_q    <= 1'b1;
        bresp_q     <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        o_wr_strobe <= wr_sel;
      end else begin
        if (aw_hs) begin
          aw_held  <= 1'b1;
          aw_idx_q <= AXI.awaddr[ADDR_W-1:LSB];
        end
        if (w_hs) begin
          w_held   <= 1'b1;
          w_data_q <= AXI.wdata;
          w_strb_q <= AXI.wstrb;
        end
      end
    end
  end

  // Read channel: capture data on the AR handshake and hold it until taken.
  // Capturing from regs with a non-blocking read means a write committing
  // on the same edge is not yet visible, so the old value is returned.
  always_ff @(posedge FCLK_CLK0) begin
    if (RST) begin
      rvalid_q    <= 1'b0;
      rresp_q     <= RESP_OKAY;
      rdata_q     <= '0;
      o_rd_strobe <= '0;
    end else begin
      o_rd_strobe <= '0;
      if (rvalid_q && AXI.rready) rvalid_q <= 1'b0;
      if (ar_hs) begin
        rvalid_q    <= 1'b1;
        rdata_q     <= rd_word;
        rresp_q     <= (|rd_sel) ? RESP_OKAY : RESP_SLVERR;
        o_rd_strobe <= rd_sel;
      end
    end
  end

  // RW contents out; RO slots are owned by fabric and read back as zero here.
  always_comb begin
    o_regs = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!RO_MASK[i]) o_regs[i*DATA_W +: DATA_W] = regs[i];
    end
  end

  // Protection bits, sub-word address bits and RW slots of i_ro_regs carry
  // no meaning for this bank.
  logic unused_bits;
  assign unused_bits = ^{AXI.awprot, AXI.arprot, AXI.awaddr[LSB-1:0],
                         AXI.araddr[LSB-1:0], i_ro_regs};

endmodule

// File: tb/tb_axi_lite_regbank.sv
// tb_axi_lite_regbank
//   Directed bench for axi_lite_regbank with NUM_REGS=8, RO_MASK=8'h0C,
//   DATA_W=32. Multi-cycle corner cases are hand-written sequences; single
//   transactions come from a table of stimulus and hand-computed results.
module tb_axi_lite_regbank;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 16;
  localparam int NUM_REGS = 8;
  localparam logic [NUM_REGS-1:0] RO_MASK = 8'h0C;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] value;
    logic [7:0]  strobe;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NUM_REGS*DATA_W-1:0] o_regs;
  logic [NUM_REGS*DATA_W-1:0] i_ro_regs;
  logic [NUM_REGS-1:0]        o_wr_strobe;
  logic [NUM_REGS-1:0]        o_rd_strobe;

  int num_checks = 0;
  int num_fails  = 0;
  logic [31:0] model [NUM_REGS];
  vec_t vecs [14];

  always #5 clk = ~clk;

  axi_lite_regbank_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  axi_lite_regbank #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .RO_MASK(RO_MASK)
  ) dut (
    .FCLK_CLK0  (clk),
    .RST        (rst),
    .AXI        (bus),
    .o_regs     (o_regs),
    .i_ro_regs  (i_ro_regs),
    .o_wr_strobe(o_wr_strobe),
    .o_rd_strobe(o_rd_strobe)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [255:0] actual,
                              input logic [255:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [255:0] model_flat();
    logic [255:0] flat;
    flat = '0;
    for (int i = 0; i < NUM_REGS; i++) flat[i*32 +: 32] = model[i];
    return flat;
  endfunction

  // One complete write or read with bready/rready high, checked against
  // the record's expected response, value and strobe.
  task automatic apply_stimulus(input vec_t v, input int n);
    int waited;
    string tag;
    tag = $sformatf("vec%0d", n);
    waited = 0;
    if (v.wr) begin
      bus.awaddr  = v.addr;
      bus.wdata   = v.data;
      bus.wstrb   = v.strb;
      bus.awvalid = 1'b1;
      bus.wvalid  = 1'b1;
      bus.bready  = 1'b1;
      tick();
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      while (!bus.bvalid && waited < 10) begin
        tick();
        waited++;
      end
      check_output({tag, " bvalid"}, 256'(bus.bvalid), 256'(1'b1));
      check_output({tag, " bresp"}, 256'(bus.bresp), 256'(v.resp));
      check_output({tag, " wr_strobe"}, 256'(o_wr_strobe), 256'(v.strobe));
      if (v.strobe != 8'h00) model[v.addr[4:2]] = v.value;
      check_output({tag, " o_regs"}, o_regs, model_flat());
      tick();
      check_output({tag, " bvalid clear"}, 256'(bus.bvalid), 256'(1'b0));
      check_output({tag, " wr_strobe clear"}, 256'(o_wr_strobe), 256'(0));
    end else begin
      bus.araddr  = v.addr;
      bus.arvalid = 1'b1;
      bus.rready  = 1'b1;
      tick();
      bus.arvalid = 1'b0;
      while (!bus.rvalid && waited < 10) begin
        tick();
        waited++;
      end
      check_output({tag, " rvalid"}, 256'(bus.rvalid), 256'(1'b1));
      check_output({tag, " rdata"}, 256'(bus.rdata), 256'(v.value));
      check_output({tag, " rresp"}, 256'(bus.rresp), 256'(v.resp));
      check_output({tag, " rd_strobe"}, 256'(o_rd_strobe), 256'(v.strobe));
      tick();
      check_output({tag, " rvalid clear"}, 256'(bus.rvalid), 256'(1'b0));
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata  = '0; bus.wstrb  = '0; bus.wvalid  = 1'b0;
    bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    i_ro_regs = '0;
    i_ro_regs[0*32 +: 32] = 32'h99999999;
    i_ro_regs[2*32 +: 32] = 32'h0BADF00D;
    i_ro_regs[3*32 +: 32] = 32'hCAFEF00D;
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;

    // Table state on entry: reg1 = 0x11111111, every other RW register 0.
    vecs[0]  = '{1'b1, 16'h0008, 32'h12345678, 4'hF, 2'b10, 32'h0,        8'h00};
    vecs[1]  = '{1'b1, 16'h0040, 32'h12345678, 4'hF, 2'b10, 32'h0,        8'h00};
    vecs[2]  = '{1'b1, 16'h0000, 32'hA5A5A5A5, 4'h5, 2'b00, 32'h00A500A5, 8'h01};
    vecs[3]  = '{1'b1, 16'h001C, 32'h0F0F0F0F, 4'hF, 2'b00, 32'h0F0F0F0F, 8'h80};
    vecs[4]  = '{1'b1, 16'h0004, 32'hFFFFFFFF, 4'h0, 2'b00, 32'h11111111, 8'h02};
    vecs[5]  = '{1'b1, 16'h0004, 32'h22334455, 4'h8, 2'b00, 32'h22111111, 8'h02};
    vecs[6]  = '{1'b1, 16'h0016, 32'h76543210, 4'hF, 2'b00, 32'h76543210, 8'h20};
    vecs[7]  = '{1'b0, 16'h0000, 32'h0,        4'h0, 2'b00, 32'h00A500A5, 8'h01};
    vecs[8]  = '{1'b0, 16'h001C, 32'h0,        4'h0, 2'b00, 32'h0F0F0F0F, 8'h80};
    vecs[9]  = '{1'b0, 16'h0040, 32'h0,        4'h0, 2'b10, 32'h0,        8'h00};
    vecs[10] = '{1'b0, 16'h0020, 32'h0,        4'h0, 2'b10, 32'h0,        8'h00};
    vecs[11] = '{1'b0, 16'h0008, 32'h0,        4'h0, 2'b00, 32'h0BADF00D, 8'h04};
    vecs[12] = '{1'b0, 16'h0004, 32'h0,        4'h0, 2'b00, 32'h22111111, 8'h02};
    vecs[13] = '{1'b0, 16'h0015, 32'h0,        4'h0, 2'b00, 32'h76543210, 8'h20};

    // Reset for two cycles, then check the idle state.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_output("rst awready", 256'(bus.awready), 256'(1'b1));
    check_output("rst wready", 256'(bus.wready), 256'(1'b1));
    check_output("rst arready", 256'(bus.arready), 256'(1'b1));
    check_output("rst bvalid", 256'(bus.bvalid), 256'(1'b0));
    check_output("rst rvalid", 256'(bus.rvalid), 256'(1'b0));
    check_output("rst bresp", 256'(bus.bresp), 256'(0));
    check_output("rst rresp", 256'(bus.rresp), 256'(0));
    check_output("rst rdata", 256'(bus.rdata), 256'(0));
    check_output("rst o_regs", o_regs, 256'(0));
    check_output("rst strobes", 256'({o_wr_strobe, o_rd_strobe}), 256'(0));

    // AW and W in the same cycle.
    bus.awaddr = 16'h0004; bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    model[1] = 32'hDEADBEEF;
    check_output("same-cycle o_regs", o_regs, model_flat());
    check_output("same-cycle bvalid", 256'(bus.bvalid), 256'(1'b1));
    check_output("same-cycle bresp", 256'(bus.bresp), 256'(0));
    check_output("same-cycle wr_strobe", 256'(o_wr_strobe), 256'(8'h02));
    tick();
    check_output("same-cycle bvalid drop", 256'(bus.bvalid), 256'(1'b0));
    check_output("same-cycle strobe drop", 256'(o_wr_strobe), 256'(0));

    // W three cycles ahead of AW, then B held with bready low.
    bus.bready = 1'b0;
    bus.wdata = 32'h000000AA; bus.wstrb = 4'h1; bus.wvalid = 1'b1;
    tick();
    bus.wvalid = 1'b0;
    check_output("w-first wready", 256'(bus.wready), 256'(1'b0));
    check_output("w-first awready", 256'(bus.awready), 256'(1'b1));
    check_output("w-first no commit", o_regs, model_flat());
    tick();
    tick();
    bus.awaddr = 16'h0004; bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    model[1] = 32'hDEADBEAA;
    check_output("w-first o_regs", o_regs, model_flat());
    check_output("w-first wr_strobe", 256'(o_wr_strobe), 256'(8'h02));
    for (int c = 0; c < 5; c++) begin
      check_output($sformatf("hold%0d bvalid", c), 256'(bus.bvalid), 256'(1'b1));
      check_output($sformatf("hold%0d bresp", c), 256'(bus.bresp), 256'(0));
      check_output($sformatf("hold%0d ready", c),
                   256'({bus.awready, bus.wready}), 256'(2'b00));
      if (c < 4) tick();
    end
    bus.bready = 1'b1;
    tick();
    check_output("hold release bvalid", 256'(bus.bvalid), 256'(1'b0));
    check_output("hold release awready", 256'(bus.awready), 256'(1'b1));

    // Read and write commit to reg1 on the same edge.
    bus.awaddr = 16'h0004; bus.wdata = 32'h11111111; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    bus.araddr = 16'h0004; bus.arvalid = 1'b1; bus.rready = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    check_output("rw-collide rdata old", 256'(bus.rdata), 256'(32'hDEADBEAA));
    model[1] = 32'h11111111;
    check_output("rw-collide o_regs", o_regs, model_flat());
    tick();
    bus.araddr = 16'h0004; bus.arvalid = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    check_output("rw-collide reread", 256'(bus.rdata), 256'(32'h11111111));
    tick();

    for (int n = 0; n < 14; n++) apply_stimulus(vecs[n], n);

    // RO read with rready held low for three cycles.
    bus.rready = 1'b0;
    bus.araddr = 16'h000C; bus.arvalid = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    check_output("ro-hold rd_strobe", 256'(o_rd_strobe), 256'(8'h08));
    for (int c = 0; c < 3; c++) begin
      check_output($sformatf("ro-hold%0d rvalid", c), 256'(bus.rvalid), 256'(1'b1));
      check_output($sformatf("ro-hold%0d rdata", c), 256'(bus.rdata), 256'(32'hCAFEF00D));
      check_output($sformatf("ro-hold%0d rresp", c), 256'(bus.rresp), 256'(0));
      check_output($sformatf("ro-hold%0d arready", c), 256'(bus.arready), 256'(1'b0));
      tick();
      check_output($sformatf("ro-hold%0d strobe once", c), 256'(o_rd_strobe), 256'(0));
    end
    bus.rready = 1'b1;
    tick();
    check_output("ro-hold rvalid drop", 256'(bus.rvalid), 256'(1'b0));
    check_output("ro-hold arready back", 256'(bus.arready), 256'(1'b1));

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
